// File: rtl/csi_pkg.sv
// Shared constants and state encoding for the CSI-2 RAW8 frame writer.
// Default geometry is 640x480 RAW8, four pixels per 32-bit RAM word.
package csi_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ADDR_W_DEF   = 17;

    localparam int PIX_PER_WORD       = 4;
    localparam int WORDS_PER_LINE_DEF = H_ACTIVE_DEF / PIX_PER_WORD;

    // CSI-2 data-type code carried by RAW8 long packets.
    localparam logic [5:0] DT_RAW8 = 6'h2A;

    typedef enum logic [1:0] {
        WAIT_FS   = 2'd0,
        WAIT_LINE = 2'd1,
        IN_LINE   = 2'd2,
        SKIP      = 2'd3
    } wr_state_e;

    function automatic int words_per_line(input int h_active);
        return h_active / PIX_PER_WORD;
    endfunction

endpackage

// File: rtl/pixel_packer_4x8.sv
// Four-lane RAW8 byte assembler: emits one 32-bit word when lane 3 is written,
// or a zero-padded partial word on flush. Output is registered (1-cycle latency).
module pixel_packer_4x8 (
    input  logic        clk,
    input  logic        srst,
    input  logic        clear_i,
    input  logic        wr_en_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  data_i,
    input  logic        flush_i,
    output logic        word_valid_o,
    output logic [31:0] word_data_o
);

    logic [31:0] lanes_q, lanes_d;
    logic [31:0] merged;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        emit;

    // A byte arriving together with a flush must land in the flushed word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign merged[8*gi +: 8] = (wr_en_i && lane_i == LANE) ? data_i : lanes_q[8*gi +: 8];
    end

    assign emit = (wr_en_i && lane_i == 2'd3) || flush_i;

    always_comb begin
        lanes_d = merged;
        valid_d = 1'b0;
        word_d  = word_q;
        if (clear_i) begin
            lanes_d = '0;
        end else if (emit) begin
            lanes_d = '0;
            valid_d = 1'b1;
            word_d  = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            lanes_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lanes_q <= lanes_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_data_o  = word_q;

endmodule

// File: rtl/csi_frame_writer.sv
// CSI-2 RAW8 line/frame sequencer: windows the byte stream to H_ACTIVE x V_ACTIVE,
// packs bytes into RAM words at row-aligned addresses and reports geometry/sync errors.
module csi_frame_writer
    import csi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              line_start,
    input  logic              line_end,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    output logic [31:0]       ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              frame_done,
    output logic              busy,
    output logic              short_line_err,
    output logic              long_line_err,
    output logic              sync_err
);

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0]  H_LIM = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0]  V_LIM = ROW_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] WPL   = ADDR_W'(words_per_line(H_ACTIVE));

    wr_state_e         state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [COL_W-1:0]  col_q, col_d, col_next;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              done_pend_q, done_pend_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              sync_q, sync_d;
    logic              pk_clear, pk_wr, pk_flush, pk_emit;
    logic              pk_valid;
    logic [31:0]       pk_data;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        col_d       = col_q;
        col_next    = col_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_pend_d = 1'b0;
        short_d     = short_q;
        long_d      = long_q;
        sync_d      = sync_q;
        pk_clear    = 1'b0;
        pk_wr       = 1'b0;
        pk_flush    = 1'b0;

        // Frame closed by an implicit line end waits one cycle so its flush lands first.
        if (done_pend_q) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end

        if (frame_start && state_q != WAIT_FS) begin
            sync_d   = 1'b1;
            pk_clear = 1'b1;
            if (capture_en) begin
                state_d    = WAIT_LINE;
                row_d      = '0;
                row_base_d = '0;
                busy_d     = 1'b1;
            end else begin
                state_d = WAIT_FS;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                WAIT_FS: begin
                    if (frame_start && capture_en) begin
                        state_d    = WAIT_LINE;
                        row_d      = '0;
                        row_base_d = '0;
                        busy_d     = 1'b1;
                    end
                end
                WAIT_LINE: begin
                    if (frame_end) begin
                        state_d = WAIT_FS;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (line_start) begin
                        state_d = IN_LINE;
                        col_d   = '0;
                    end
                end
                IN_LINE: begin
                    if (line_start) begin
                        sync_d   = 1'b1;
                        pk_clear = 1'b1;
                        col_d    = '0;
                    end else begin
                        if (pix_valid) begin
                            if (col_q < H_LIM) begin
                                pk_wr    = 1'b1;
                                col_next = col_q + 1'b1;
                            end else begin
                                long_d = 1'b1;
                            end
                        end
                        col_d = col_next;
                        if (line_end || frame_end) begin
                            if (col_next < H_LIM) short_d = 1'b1;
                            pk_flush   = (col_next[1:0] != 2'd0);
                            row_d      = row_q + 1'b1;
                            row_base_d = row_base_q + WPL;
                            if (frame_end) begin
                                state_d = WAIT_FS;
                                if (pk_flush) begin
                                    done_pend_d = 1'b1;
                                end else begin
                                    done_d = 1'b1;
                                    busy_d = 1'b0;
                                end
                            end else if (row_d == V_LIM) begin
                                state_d = SKIP;
                            end else begin
                                state_d = WAIT_LINE;
                            end
                        end
                    end
                end
                SKIP: begin
                    if (frame_end) begin
                        state_d = WAIT_FS;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = WAIT_FS;
            endcase
        end
    end

    // The word address belongs to the word the packer emits this cycle.
    assign pk_emit = (pk_wr && col_q[1:0] == 2'd3) || pk_flush;
    assign addr_d  = pk_emit ? (row_base_q + ADDR_W'(col_q >> 2)) : addr_q;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= WAIT_FS;
            row_q       <= '0;
            row_base_q  <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_pend_q <= done_pend_d;
            short_q     <= short_d;
            long_q      <= long_d;
            sync_q      <= sync_d;
        end
    end

    pixel_packer_4x8 u_packer (
        .clk          (sys_clk),
        .srst         (reset),
        .clear_i      (pk_clear),
        .wr_en_i      (pk_wr),
        .lane_i       (col_q[1:0]),
        .data_i       (pix_data),
        .flush_i      (pk_flush),
        .word_valid_o (pk_valid),
        .word_data_o  (pk_data)
    );

    assign ram_we         = pk_valid;
    assign ram_data       = pk_data;
    assign ram_addr       = addr_q;
    assign frame_done     = done_q;
    assign busy           = busy_q;
    assign short_line_err = short_q;
    assign long_line_err  = long_q;
    assign sync_err       = sync_q;

endmodule
